// File: rtl/param_register_file.sv
// param_register_file: multi-read-port register file with pending-write scoreboard and sequential clear.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module param_register_file #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int NUM_READ = 5,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [NUM_READ*AW-1:0]    RdAddr,
   output logic [NUM_READ*WIDTH-1:0] RdData,
   input  logic                      WrEnable,
   input  logic [AW-1:0]             WrAddr,
   input  logic [WIDTH-1:0]          WrData,
   input  logic                      SbSetEn,
   input  logic [AW-1:0]             SbSetAddr,
   output logic [DEPTH-1:0]          Pending,
   input  logic                      ClearReq,
   output logic                      ClearBusy
);
   typedef enum logic {S_IDLE, S_CLEAR} state_t;
   state_t               r_state;
   logic [AW-1:0]        r_cnt;
   logic [DEPTH-1:0]     r_pend;
   logic                 r_busy;
   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic                 w_wr_ok;
   logic                 w_sb_ok;
   logic [DEPTH-1:0]     w_wr_mask;
   logic [DEPTH-1:0]     w_sb_mask;

   // Register 0 and out-of-range addresses never accept writes or scoreboard sets.
   assign w_wr_ok   = r_state == S_IDLE && !ClearReq && WrEnable && WrAddr != '0 && 32'(WrAddr) < DEPTH;
   assign w_sb_ok   = r_state == S_IDLE && !ClearReq && SbSetEn && SbSetAddr != '0 && 32'(SbSetAddr) < DEPTH;
   assign w_wr_mask = w_wr_ok ? DEPTH'(1) << WrAddr : '0;
   assign w_sb_mask = w_sb_ok ? DEPTH'(1) << SbSetAddr : '0;
   assign Pending   = r_pend;
   assign ClearBusy = r_busy;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= AW'(1);
         r_pend  <= '0;
         r_busy  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == S_IDLE) begin
         if (ClearReq) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= AW'(1);
            r_pend  <= '0;
         end else begin
            if (w_wr_ok) r_mem[WrAddr] <= WrData;
            // A new issue outranks a same-edge writeback to the same register.
            r_pend <= (r_pend & ~w_wr_mask) | w_sb_mask;
         end
      end else begin
         r_mem[r_cnt] <= '0;
         if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= AW'(1);
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_fwd;
      assign w_a = RdAddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign w_fwd = w_wr_ok && w_a == WrAddr;
`else
      assign w_fwd = 1'b0;
`endif
      assign RdData[k*WIDTH +: WIDTH] = (!Reset || w_a == '0 || 32'(w_a) >= DEPTH) ? '0 :
                                        w_fwd ? WrData : r_mem[w_a];
   end
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed self-checking bench for param_register_file at default parameters.
module tb_param_register_file;
   localparam int W = 16, D = 16, NR = 5, AW = 4;
   logic              Clock = 1'b0;
   logic              Reset = 1'b0;
   logic [NR*AW-1:0]  RdAddr = '0;
   logic [NR*W-1:0]   RdData;
   logic              WrEnable = 1'b0;
   logic [AW-1:0]     WrAddr = '0;
   logic [W-1:0]      WrData = '0;
   logic              SbSetEn = 1'b0;
   logic [AW-1:0]     SbSetAddr = '0;
   logic [D-1:0]      Pending;
   logic              ClearReq = 1'b0;
   logic              ClearBusy;
   int                n_chk = 0;
   int                n_fail = 0;
   int                n_busy;

   param_register_file dut (
      .Clock(Clock), .Reset(Reset), .RdAddr(RdAddr), .RdData(RdData),
      .WrEnable(WrEnable), .WrAddr(WrAddr), .WrData(WrData),
      .SbSetEn(SbSetEn), .SbSetAddr(SbSetAddr), .Pending(Pending),
      .ClearReq(ClearReq), .ClearBusy(ClearBusy)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic rd_all(input logic [AW-1:0] a);
      RdAddr = {NR{a}};
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] exp);
      #1;
      for (int k = 0; k < NR; k++) chk(tag, 64'(RdData[k*W +: W]), 64'(exp));
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      WrEnable = 1'b1; WrAddr = a; WrData = d;
      tick();
      WrEnable = 1'b0;
   endtask

   initial begin
      rd_all(4'd5);
      #3;
      chk("rst_rd", 64'(RdData), 64'(0));
      chk("rst_pend", 64'(Pending), 64'(0));
      chk("rst_busy", 64'(ClearBusy), 64'(0));
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      wr(4'd5, 16'hBEEF);
      chk_all("rd_r5", 16'hBEEF);
      wr(4'd0, 16'h1234);
      rd_all(4'd0);
      chk_all("rd_r0", 16'h0000);
      SbSetEn = 1'b1; SbSetAddr = 4'd0;
      tick();
      SbSetEn = 1'b0;
      chk("pend_r0", 64'(Pending), 64'(0));
      SbSetEn = 1'b1; SbSetAddr = 4'd3;
      tick();
      SbSetEn = 1'b0;
      chk("pend_set3", 64'(Pending), 64'h0008);
      tick();
      wr(4'd3, 16'h0333);
      chk("pend_clr3", 64'(Pending), 64'h0000);
      SbSetEn = 1'b1; SbSetAddr = 4'd3;
      wr(4'd3, 16'h0444);
      SbSetEn = 1'b0;
      chk("pend_both3", 64'(Pending), 64'h0008);
      rd_all(4'd3);
      chk_all("rd_r3", 16'h0444);
      rd_all(4'd7);
      WrEnable = 1'b1; WrAddr = 4'd7; WrData = 16'hA5A5;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_r7", 64'(RdData[W-1:0]), 64'hA5A5);
`else
      chk("byp_r7", 64'(RdData[W-1:0]), 64'h0000);
`endif
      tick();
      WrEnable = 1'b0;
      chk_all("rd_r7", 16'hA5A5);
      for (int i = 1; i < D; i++) wr(AW'(i), 16'h1000 + 16'(i));
      RdAddr = {4'd15, 4'd9, 4'd2, 4'd1, 4'd7};
      #1;
      chk("fill_p0", 64'(RdData[0 +: W]), 64'h1007);
      chk("fill_p1", 64'(RdData[W +: W]), 64'h1001);
      chk("fill_p2", 64'(RdData[2*W +: W]), 64'h1002);
      chk("fill_p4", 64'(RdData[4*W +: W]), 64'h100F);
      chk("fill_pend", 64'(Pending), 64'h0000);
      SbSetEn = 1'b1; SbSetAddr = 4'd9;
      tick();
      chk("pend_set9", 64'(Pending), 64'h0200);
      // Clear request collides with a write to r2, which must be dropped.
      ClearReq = 1'b1; SbSetAddr = 4'd6; WrEnable = 1'b1; WrAddr = 4'd2; WrData = 16'hFFFF;
      tick();
      ClearReq = 1'b0;
      WrAddr = 4'd4; WrData = 16'hDEAD;
      #1;
      chk("clr_busy", 64'(ClearBusy), 64'(1));
      chk("clr_pend", 64'(Pending), 64'(0));
      chk("clr_r2", 64'(RdData[2*W +: W]), 64'h1002);
      chk("clr_r1", 64'(RdData[W +: W]), 64'h1001);
      n_busy = 0;
      for (int t = 0; t < 100 && ClearBusy; t++) begin
         tick();
         n_busy++;
      end
      WrEnable = 1'b0; SbSetEn = 1'b0;
      chk("clr_len", 64'(n_busy), 64'(15));
      chk("clr_done", 64'(ClearBusy), 64'(0));
      chk("clr_pend2", 64'(Pending), 64'(0));
      for (int i = 1; i < D; i++) begin
         rd_all(AW'(i));
         #1;
         chk("clr_zero", 64'(RdData), 64'(0));
      end
      wr(4'd12, 16'h0077);
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      repeat (4) tick();
      rd_all(4'd12);
      #1;
      chk("mid_r12", 64'(RdData[W-1:0]), 64'h0077);
      Reset = 1'b0;
      #1;
      chk("mid_rd", 64'(RdData), 64'(0));
      chk("mid_busy", 64'(ClearBusy), 64'(0));
      chk("mid_pend", 64'(Pending), 64'(0));
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      chk("post_busy", 64'(ClearBusy), 64'(0));
      wr(4'd13, 16'h3333);
      repeat (16) tick();
      rd_all(4'd13);
      chk_all("post_r13", 16'h3333);
      chk("post_busy2", 64'(ClearBusy), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
